cam_lutram_updater: RTL and testbench
=====================================

Name: cam_lutram_updater

Overview:
- Update sequencer that sits directly upstream of the bank of distributed-RAM slices forming a LUTRAM-based CAM.
- Accepts one write or delete request per entry and sweeps every slice address, doing a read-modify-write of the entry's bit column.
- Drives the slices' wen/addr/din and consumes their combinational dout.
- Search-path arbitration, which muxes search addresses against ram_addr using busy, lives outside this block.

Parameters:
- Depth, 64, words per LUTRAM slice; must be a power of 2; AW = $clog2(Depth).
- Width, 32, CAM entries (slice word width, one bit per entry); IW = $clog2(Width).
- KeyWidth, 12, search key width; must be a multiple of AW; localparam Blocks = KeyWidth/AW.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  update request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  1  0 = OP_DELETE, 1 = OP_WRITE.
- req_index  in  IW  entry number (bit column) to update.
- req_key  in  KeyWidth  key to store (ignored for delete).
- busy  out  1  sweep in progress; search path must not drive slice addresses.
- done  out  1  one-cycle pulse, update complete.
- ram_wen  out  1  write enable, common to all slices.
- ram_addr  out  AW  address, common to all slices.
- ram_din  out  Blocks x Width  write data, per slice.
- ram_dout  in  Blocks x Width  combinational read data of ram_addr, per slice.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state = IDLE, addr counter = 0, latched op/index/key = 0; req_ready = 0 while rst is high, else follows state.
- Outputs while in reset: busy = 0, done = 0, ram_wen = 0, ram_addr = 0, ram_din = ram_dout (passthrough).
- Handshake: accept when req_valid && req_ready.
  - req_ready = 1 only in IDLE (and rst low).
  - On accept, latch op, index and key; go to SWEEP with counter = 0.
  - req_valid held in non-IDLE states is ignored and not queued.
- States:
  - IDLE: no writes; ram_wen = 0.
  - SWEEP: ram_wen = 1, busy = 1, ram_addr = counter; counter increments each cycle. At counter == Depth-1, go to DONE (counter wraps to 0).
  - DONE: done = 1, busy = 0, ram_wen = 0; then IDLE.
- Write data per slice b, for every bit j:
  - slice key k_b = key[b*AW +: AW].
  - j != index: ram_din[b][j] = ram_dout[b][j].
  - j == index: 1 if op == OP_WRITE and counter == k_b, else 0.
  - A write therefore clears any old key for that entry and sets the new one in one sweep; a delete clears the column.
- Latency: accept at cycle t; writes at cycles t+1 .. t+Depth; done at t+Depth+1; req_ready high at t+Depth+2. Back-to-back throughput is one request per Depth+2 cycles.
- Boundaries:
  - req_index >= Width (Width not a power of 2): the sweep still runs, all din = dout (no-op), done still pulses.
  - A request arriving in the same cycle as done is not accepted (req_ready = 0).
  - rst mid-SWEEP: return to IDLE next cycle, ram_wen = 0, no done pulse. The entry's column is then partially updated and undefined; software must re-issue the request.
  - Writes to other entries' bits are always the read-back value. Concurrent external writes to the slices during busy are forbidden.

Decomposition:
- Package cam_pkg holds:
  - the op enum (OP_DELETE = 1'b0, OP_WRITE = 1'b1);
  - the state enum (IDLE, SWEEP, DONE);
  - a function returning slice b of a key for given AW.
- No sub-module. LUTRAM slice instances and the search/update address mux belong to the enclosing CAM top; this block is a single FSM plus datapath.

Test Plan (Depth=64, Width=32, KeyWidth=12, Blocks=2, slices modelled as LUTRAMs):
- Reset, then write idx=5, key=0x0A3 -> done 65 cycles after accept.
  - Slice0 (k=0x23=35): bit5 = 1 only at addr 35.
  - Slice1 (k=0x02): bit5 = 1 only at addr 2.
  - All other bits unchanged.
- Preload entry 7 with key 0x000, then write idx=7, key=0xFFF -> bit7 cleared at addr 0 of both slices and set at addr 63 of both; entry 5 contents untouched.
- Delete idx=5 -> bit5 = 0 at all 64 addresses of both slices; busy high exactly 64 cycles.
- Hold req_valid high with two requests -> second accepted 66 cycles after the first; req_ready low throughout SWEEP and DONE.
- Assert rst at sweep cycle 20 -> ram_wen = 0 next cycle, no done pulse, req_ready = 1 the first cycle after rst drops.
- Width=30 build, req_index=31 -> full sweep, slice contents bit-identical before and after, done pulses.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the LUTRAM CAM update sequencer.
package cam_pkg;

  typedef enum logic {
    OP_DELETE = 1'b0,
    OP_WRITE  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned KeyMaxW = 64;

  // Slice b of a key when each slice is addressed by aw key bits.
  function automatic logic [KeyMaxW-1:0] key_slice(input logic [KeyMaxW-1:0] key,
                                                   input int unsigned       b,
                                                   input int unsigned       aw);
    logic [KeyMaxW-1:0] mask;
    mask = (KeyMaxW'(1) << aw) - KeyMaxW'(1);
    return (key >> (b * aw)) & mask;
  endfunction

endpackage

// File: rtl/cam_lutram_updater.sv
// Sweeps every LUTRAM slice address, read-modify-writing one entry's bit column
// so that the entry matches exactly its new key (write) or nothing (delete).
module cam_lutram_updater
  import cam_pkg::*;
#(
  parameter int unsigned Depth    = 64,
  parameter int unsigned Width    = 32,
  parameter int unsigned KeyWidth = 12
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  input  logic                                               req_op,
  input  logic [$clog2(Width)-1:0]                           req_index,
  input  logic [KeyWidth-1:0]                                req_key,
  output logic                                               busy,
  output logic                                               done,
  output logic                                               ram_wen,
  output logic [$clog2(Depth)-1:0]                           ram_addr,
  output logic [KeyWidth/$clog2(Depth)-1:0][Width-1:0]       ram_din,
  input  logic [KeyWidth/$clog2(Depth)-1:0][Width-1:0]       ram_dout
);

  localparam int unsigned AW     = $clog2(Depth);
  localparam int unsigned IW     = $clog2(Width);
  localparam int unsigned Blocks = KeyWidth / AW;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  op_e                 op_q, op_d;
  logic [IW-1:0]       index_q, index_d;
  logic [KeyWidth-1:0] key_q, key_d;
  logic [AW-1:0]       slice_k;

  // State and request latch register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= OP_DELETE;
      index_q <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      index_q <= index_d;
      key_q   <= key_d;
    end
  end

  // Next state, handshake and slice write datapath.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    index_d   = index_q;
    key_d     = key_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_din   = ram_dout;
    slice_k   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          op_d    = op_e'(req_op);
          index_d = req_index;
          key_d   = req_key;
          addr_d  = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        addr_d = addr_q + AW'(1);
        if (addr_q == AW'(Depth - 1)) state_d = DONE;
        if (!rst) begin
          busy     = 1'b1;
          ram_wen  = 1'b1;
          ram_addr = addr_q;
          // Only the selected column changes; an out-of-range index matches no bit.
          for (int unsigned b = 0; b < Blocks; b++) begin
            slice_k = AW'(key_slice(KeyMaxW'(key_q), b, AW));
            for (int unsigned j = 0; j < Width; j++) begin
              if (index_q == IW'(j)) ram_din[b][j] = (op_q == OP_WRITE) && (addr_q == slice_k);
            end
          end
        end
      end
      DONE: begin
        done    = !rst;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_lutram_updater.sv
// Bench for cam_lutram_updater: LUTRAM slices modelled as arrays, entry-level reference model.
module tb_cam_lutram_updater;
  import cam_pkg::*;

  localparam int unsigned Depth = 64, Width = 32, KeyWidth = 12, AW = 6, Blocks = 2, W2 = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                             req_valid, req_ready, req_op, busy, done, ram_wen;
  logic [4:0]                       req_index;
  logic [KeyWidth-1:0]              req_key;
  logic [AW-1:0]                    ram_addr;
  logic [Blocks-1:0][Width-1:0]     ram_din, ram_dout;
  logic [Width-1:0]                 mem0 [Blocks][Depth];

  logic                             w2_valid, w2_ready, w2_op, w2_busy, w2_done, w2_wen;
  logic [4:0]                       w2_index;
  logic [KeyWidth-1:0]              w2_key;
  logic [AW-1:0]                    w2_addr;
  logic [Blocks-1:0][W2-1:0]        w2_din, w2_dout;
  logic [W2-1:0]                    mem2 [Blocks][Depth];
  logic [W2-1:0]                    snap2 [Blocks][Depth];

  cam_lutram_updater #(.Depth(Depth), .Width(Width), .KeyWidth(KeyWidth)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_key(req_key), .busy(busy), .done(done), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  cam_lutram_updater #(.Depth(Depth), .Width(W2), .KeyWidth(KeyWidth)) dut30 (
    .clk(clk), .rst(rst), .req_valid(w2_valid), .req_ready(w2_ready), .req_op(w2_op),
    .req_index(w2_index), .req_key(w2_key), .busy(w2_busy), .done(w2_done), .ram_wen(w2_wen),
    .ram_addr(w2_addr), .ram_din(w2_din), .ram_dout(w2_dout));

  // LUTRAM slices: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_wen) for (int b = 0; b < Blocks; b++) mem0[b][ram_addr] <= ram_din[b];
    if (w2_wen)  for (int b = 0; b < Blocks; b++) mem2[b][w2_addr] <= w2_din[b];
  end
  always_comb begin
    for (int b = 0; b < Blocks; b++) begin
      ram_dout[b] = mem0[b][ram_addr];
      w2_dout[b]  = mem2[b][w2_addr];
    end
  end

  int nvec = 0;
  int nerr = 0;

  // Entry-level model: 0 empty, 1 holds ekey, 2 column undefined.
  int               est  [Width];
  logic [11:0]      ekey [Width];

  typedef struct {
    logic        op;
    int          idx;
    logic [11:0] key;
    int          exp_lat;
    int          exp_busy;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_apply(input logic op, input int idx, input logic [11:0] key);
    if (idx < int'(Width)) begin
      est[idx]  = op ? 1 : 0;
      ekey[idx] = key;
    end
  endfunction

  task automatic check_mem(input string tag);
    logic [Width-1:0] exp, mask;
    for (int b = 0; b < Blocks; b++) begin
      for (int a = 0; a < Depth; a++) begin
        exp = '0;
        mask = '1;
        for (int e = 0; e < Width; e++) begin
          if (est[e] == 2) mask[e] = 1'b0;
          else if (est[e] == 1 && int'((ekey[e] >> (b * AW)) & 12'h3F) == a) exp[e] = 1'b1;
        end
        chk($sformatf("%s mem[%0d][%0d]", tag, b, a), 64'(mem0[b][a] & mask), 64'(exp));
      end
    end
  endtask

  // Issue one request on the Width=32 instance and track its handshake timing.
  task automatic run_req(input logic op, input int idx, input logic [11:0] key,
                         output int lat, output int bcnt);
    int n, rdy_bad;
    lat = -1; bcnt = 0; rdy_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_index = 5'(idx); req_key = key;
    chk("ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (n < 200 && lat < 0) begin
      if (busy) bcnt++;
      if (req_ready) rdy_bad++;
      if (done) lat = n;
      if (lat < 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk("ready_low_while_active", 64'(rdy_bad), 64'd0);
    @(negedge clk);
    chk("ready_after_done", 64'(req_ready), 64'd1);
    chk("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, n, seen_done, diff;
    logic op;
    int idx;
    logic [11:0] key;

    tbl[0] = '{1'b1, 5, 12'h0A3, 65, 64};
    tbl[1] = '{1'b1, 7, 12'h000, 65, 64};
    tbl[2] = '{1'b1, 7, 12'hFFF, 65, 64};
    tbl[3] = '{1'b0, 5, 12'h000, 65, 64};

    req_valid = 1'b0; req_op = 1'b0; req_index = '0; req_key = '0;
    w2_valid = 1'b0; w2_op = 1'b0; w2_index = '0; w2_key = '0;
    for (int e = 0; e < Width; e++) begin est[e] = 0; ekey[e] = '0; end
    for (int b = 0; b < Blocks; b++)
      for (int a = 0; a < Depth; a++) begin
        mem0[b][a] = '0;
        mem2[b][a] = W2'($urandom);
        snap2[b][a] = mem2[b][a];
      end

    // Reset behaviour.
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_din_passthru", 64'(ram_din), 64'(ram_dout));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      run_req(tbl[i].op, tbl[i].idx, tbl[i].key, lat, bcnt);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_busy_cycles", i), 64'(bcnt), 64'(tbl[i].exp_busy));
      model_apply(tbl[i].op, tbl[i].idx, tbl[i].key);
      if (i == 0) begin
        chk("w5_s0_a35", 64'(mem0[0][35][5]), 64'd1);
        chk("w5_s0_a34", 64'(mem0[0][34][5]), 64'd0);
        chk("w5_s1_a2", 64'(mem0[1][2][5]), 64'd1);
      end
      if (i == 2) begin
        chk("w7_s0_a0", 64'(mem0[0][0][7]), 64'd0);
        chk("w7_s1_a0", 64'(mem0[1][0][7]), 64'd0);
        chk("w7_s0_a63", 64'(mem0[0][63][7]), 64'd1);
        chk("w7_s1_a63", 64'(mem0[1][63][7]), 64'd1);
      end
      check_mem($sformatf("tbl%0d", i));
    end

    // Back-to-back: req_valid held high across two requests.
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_index = 5'd3; req_key = 12'h5C1;
    chk("b2b_first_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_index = 5'd4; req_key = 12'h3E7;
    n = 1; seen_done = 0;
    while (n < 200 && !req_ready) begin
      if (done) seen_done = n;
      @(negedge clk);
      n++;
    end
    chk("b2b_second_accept", 64'(n), 64'd66);
    chk("b2b_first_done", 64'(seen_done), 64'd65);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; lat = -1;
    while (n < 200 && lat < 0) begin
      if (done) lat = n;
      @(negedge clk);
      n++;
    end
    chk("b2b_second_done", 64'(lat), 64'd65);
    model_apply(1'b1, 3, 12'h5C1);
    model_apply(1'b1, 4, 12'h3E7);
    check_mem("b2b");

    // Reset in the middle of a sweep.
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_index = 5'd9; req_key = 12'hABC;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_wen", 64'(ram_wen), 64'd1);
    chk("mid_addr", 64'(ram_addr), 64'd19);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wen", 64'(ram_wen), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", 64'(req_ready), 64'd1);
    seen_done = 0;
    for (int k = 0; k < 80; k++) begin
      if (done || ram_wen) seen_done++;
      @(negedge clk);
    end
    chk("rst_mid_no_activity", 64'(seen_done), 64'd0);
    est[9] = 2;
    check_mem("rst_mid");
    run_req(1'b1, 9, 12'hABC, lat, bcnt);
    chk("reissue_latency", 64'(lat), 64'd65);
    model_apply(1'b1, 9, 12'hABC);
    check_mem("reissue");

    // Random requests against the model.
    for (int r = 0; r < 6; r++) begin
      op  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, Width - 1));
      key = 12'($urandom);
      run_req(op, idx, key, lat, bcnt);
      chk($sformatf("rnd%0d_latency", r), 64'(lat), 64'd65);
      chk($sformatf("rnd%0d_busy_cycles", r), 64'(bcnt), 64'd64);
      model_apply(op, idx, key);
      check_mem($sformatf("rnd%0d", r));
    end

    // Width=30 instance with an out-of-range index: full sweep, no data change.
    @(negedge clk);
    w2_valid = 1'b1; w2_op = 1'b1; w2_index = 5'd31; w2_key = 12'h123;
    chk("w30_ready", 64'(w2_ready), 64'd1);
    @(negedge clk);
    w2_valid = 1'b0;
    n = 1; lat = -1; bcnt = 0;
    while (n < 200 && lat < 0) begin
      if (w2_busy) bcnt++;
      if (w2_done) lat = n;
      if (lat < 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk("w30_latency", 64'(lat), 64'd65);
    chk("w30_busy_cycles", 64'(bcnt), 64'd64);
    diff = 0;
    for (int b = 0; b < Blocks; b++)
      for (int a = 0; a < Depth; a++)
        if (mem2[b][a] !== snap2[b][a]) diff++;
    chk("w30_words_changed", 64'(diff), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
